// File: rtl/apb4_mem_slave_if.sv
// apb4_mem_slave_if
//   APB4 bus bundle between a requester (master modport) and the memory
//   completer (slave modport).
//   psel/penable/pwrite/paddr/pwdata/pstrb : requester -> completer
//   prdata/pready/pslverr                  : completer -> requester
interface apb4_mem_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   localparam int NB = DATA_WIDTH / 8;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [NB-1:0]         pstrb;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb4_mem_slave.sv
// apb4_mem_slave
//   Word-organised RAM behind an APB4 completer with programmable wait
//   states, byte strobes, a read-only low region, error decode (range,
//   alignment, read-only write) and a saturating error counter.
//   Ports:
//     pclk      : APB clock, rising edge
//     presetn   : asynchronous active-low reset
//     bus       : APB4 slave modport (psel, penable, pwrite, paddr, pwdata,
//                 pstrb in; prdata, pready, pslverr out)
//     err_count : saturating count of error responses (stops at 255)
module apb4_mem_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0,
   parameter int RO_WORDS    = 4
) (
   input  logic                pclk,
   input  logic                presetn,
   apb4_mem_slave_if.slave     bus,
   output logic [7:0]          err_count
);

   localparam int NB   = DATA_WIDTH / 8;
   localparam int BW   = $clog2(NB);
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(NB - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   // Any one cause is enough; no priority among them.
   function automatic logic decode_err(input logic [ADDR_WIDTH-1:0] a,
                                       input logic                  wr);
      logic [31:0] w;
      w = 32'(a >> BW);
      return (w >= 32'(DEPTH)) ||
             ((a & ADDR_MASK) != '0) ||
             (wr && (w < 32'(RO_WORDS)));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_w,
      input logic [DATA_WIDTH-1:0] new_w,
      input logic [NB-1:0]         strb);
      logic [DATA_WIDTH-1:0] r;
      r = old_w;
      for (int b = 0; b < NB; b++)
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [0:0]            state;
   logic [3:0]            cnt;
   logic                  wr_q;
   logic [IDXW-1:0]       idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NB-1:0]         strb_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] prdata_q;

   logic                  setup;
   logic                  complete;
   logic                  err_s;
   logic [IDXW-1:0]       idx_s;

   assign setup    = (state == S_IDLE) && bus.psel && !bus.penable;
   assign complete = (state == S_ACCESS) && bus.psel && bus.penable && (cnt == 4'd0);
   assign err_s    = decode_err(bus.paddr, bus.pwrite);
   // Truncated index is only used when err_s is clear, i.e. when in range.
   assign idx_s    = IDXW'(bus.paddr >> BW);

   // pready is decoded from state so an async reset or a psel drop
   // removes it in the same cycle.
   assign bus.pready  = complete;
   assign bus.pslverr = complete && err_q;
   assign bus.prdata  = prdata_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         wr_q      <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         err_count <= 8'd0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (setup) begin
                  // Setup phase: capture the request and pre-read the word.
                  wr_q    <= bus.pwrite;
                  idx_q   <= idx_s;
                  wdata_q <= bus.pwdata;
                  strb_q  <= bus.pstrb;
                  err_q   <= err_s;
                  if (!bus.pwrite)
                     prdata_q <= err_s ? '0 : mem[idx_s];
                  cnt     <= 4'(WAIT_CYCLES);
                  state   <= S_ACCESS;
               end
            end
            default: begin
               // Access phase: wait out cnt, then complete or abort.
               if (!bus.psel) begin
                  state <= S_IDLE;
               end else if (bus.penable) begin
                  if (cnt != 4'd0) begin
                     cnt <= cnt - 4'd1;
                  end else begin
                     if (err_q)
                        err_count <= sat_inc(err_count);
                     else if (wr_q)
                        mem[idx_q] <= merge_bytes(mem[idx_q], wdata_q, strb_q);
                     state <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// tb_apb4_mem_slave
//   Drives three instances (0, 2 and 3 wait states) from one set of bus
//   variables; psel is routed to the instance chosen by dsel. A word-array
//   reference model predicts read data, error responses and err_count.
module tb_apb4_mem_slave;

   logic pclk = 1'b0;
   logic presetn = 1'b0;
   always #5 pclk = ~pclk;

   int dsel = 0;
   logic        t_psel = 1'b0, t_penable = 1'b0, t_pwrite = 1'b0;
   logic [11:0] t_paddr = '0;
   logic [31:0] t_pwdata = '0;
   logic [3:0]  t_pstrb = '0;

   apb4_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) if0 ();
   apb4_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) if1 ();
   apb4_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) if2 ();

   assign if0.psel = t_psel && (dsel == 0);
   assign if1.psel = t_psel && (dsel == 1);
   assign if2.psel = t_psel && (dsel == 2);
   assign if0.penable = t_penable;  assign if1.penable = t_penable;  assign if2.penable = t_penable;
   assign if0.pwrite  = t_pwrite;   assign if1.pwrite  = t_pwrite;   assign if2.pwrite  = t_pwrite;
   assign if0.paddr   = t_paddr;    assign if1.paddr   = t_paddr;    assign if2.paddr   = t_paddr;
   assign if0.pwdata  = t_pwdata;   assign if1.pwdata  = t_pwdata;   assign if2.pwdata  = t_pwdata;
   assign if0.pstrb   = t_pstrb;    assign if1.pstrb   = t_pstrb;    assign if2.pstrb   = t_pstrb;

   logic [7:0] ec0, ec1, ec2;

   apb4_mem_slave #(.WAIT_CYCLES(0)) u0 (.pclk(pclk), .presetn(presetn), .bus(if0), .err_count(ec0));
   apb4_mem_slave #(.WAIT_CYCLES(2)) u1 (.pclk(pclk), .presetn(presetn), .bus(if1), .err_count(ec1));
   apb4_mem_slave #(.WAIT_CYCLES(3)) u2 (.pclk(pclk), .presetn(presetn), .bus(if2), .err_count(ec2));

   logic        o_pready, o_pslverr;
   logic [31:0] o_prdata;
   logic [7:0]  o_errc;

   always_comb begin
      o_pready  = if0.pready;
      o_pslverr = if0.pslverr;
      o_prdata  = if0.prdata;
      o_errc    = ec0;
      if (dsel == 1) begin
         o_pready = if1.pready; o_pslverr = if1.pslverr; o_prdata = if1.prdata; o_errc = ec1;
      end else if (dsel == 2) begin
         o_pready = if2.pready; o_pslverr = if2.pslverr; o_prdata = if2.prdata; o_errc = ec2;
      end
   end

   // Reference model
   int          waits [3] = '{0, 2, 3};
   logic [31:0] mem_m [3][256];
   int          errc_m [3];

   int total = 0;
   int bad   = 0;

   function automatic bit m_err(logic [11:0] a, bit wr);
      int idx;
      idx = int'(a) / 4;
      return (idx >= 256) || (int'(a) % 4 != 0) || (wr && idx < 4);
   endfunction

   function automatic logic [31:0] m_mask(logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
      return m;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         errc_m[d] = 0;
         for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_errc(input int d);
      dsel = d;
      @(negedge pclk);
      chk("err_count", 32'(o_errc), 32'(errc_m[d]));
   endtask

   // One complete APB transfer; returns the prdata seen at completion.
   task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] s,
                       input bit b2b, output logic [31:0] rd_obs);
      bit          err;
      logic [31:0] exp_rd;
      int          idx;
      if (!b2b) begin @(posedge pclk); #1; end
      dsel = d; t_psel = 1'b1; t_penable = 1'b0; t_pwrite = wr;
      t_paddr = a; t_pwdata = wd; t_pstrb = s;
      @(negedge pclk);
      chk("setup_pready", 32'(o_pready), 32'd0);
      @(posedge pclk); #1;
      t_penable = 1'b1;
      err    = m_err(a, wr);
      idx    = int'(a) / 4;
      exp_rd = err ? 32'd0 : mem_m[d][idx];
      rd_obs = '0;
      for (int k = 0; k <= waits[d]; k++) begin
         @(negedge pclk);
         chk($sformatf("pready_A%0d", k), 32'(o_pready), 32'(k == waits[d]));
         if (k == waits[d]) begin
            chk("pslverr", 32'(o_pslverr), 32'(err));
            rd_obs = o_prdata;
            if (!wr) chk("prdata", o_prdata, exp_rd);
         end else begin
            @(posedge pclk); #1;
         end
      end
      @(posedge pclk); #1;
      t_psel = 1'b0; t_penable = 1'b0;
      if (err) begin
         if (errc_m[d] < 255) errc_m[d]++;
      end else if (wr) begin
         mem_m[d][idx] = (mem_m[d][idx] & ~m_mask(s)) | (wd & m_mask(s));
      end
   endtask

   logic [31:0] rd;
   logic [11:0] ra;

   initial begin
      model_clear();
      // Reset state of every instance
      repeat (2) @(posedge pclk);
      for (int d = 0; d < 3; d++) begin
         dsel = d;
         @(negedge pclk);
         chk("rst_pready", 32'(o_pready), 32'd0);
         chk("rst_pslverr", 32'(o_pslverr), 32'd0);
         chk("rst_prdata", o_prdata, 32'd0);
         chk("rst_errc", 32'(o_errc), 32'd0);
      end
      @(negedge pclk); presetn = 1'b1;

      // Zero-wait read of a reset word
      xfer(0, 1'b0, 12'h010, 32'h0, 4'hF, 1'b0, rd);
      chk("t1_rd", rd, 32'h0);

      // Two wait states: full write then read back
      xfer(1, 1'b1, 12'h104, 32'hDEADBEEF, 4'hF, 1'b0, rd);
      xfer(1, 1'b0, 12'h104, 32'h0, 4'h0, 1'b0, rd);
      chk("t2_rd", rd, 32'hDEADBEEF);

      // Byte strobes
      xfer(1, 1'b1, 12'h104, 32'h11223344, 4'b0101, 1'b0, rd);
      xfer(1, 1'b0, 12'h104, 32'h0, 4'h0, 1'b0, rd);
      chk("t3_rd", rd, 32'hDE22BE44);

      // Read-only region
      xfer(1, 1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, 1'b0, rd);
      chk_errc(1);
      chk("t4_errc", 32'(o_errc), 32'd1);
      xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, 1'b0, rd);
      chk("t4_rd", rd, 32'h0);

      // Out of range and misaligned reads
      xfer(1, 1'b0, 12'h400, 32'h0, 4'h0, 1'b0, rd);
      xfer(1, 1'b0, 12'h102, 32'h0, 4'h0, 1'b0, rd);
      chk_errc(1);
      chk("t5_errc", 32'(o_errc), 32'd3);

      // Empty strobe write is a legal no-op
      xfer(1, 1'b1, 12'h104, 32'hA5A5A5A5, 4'h0, 1'b0, rd);
      xfer(1, 1'b0, 12'h104, 32'h0, 4'h0, 1'b0, rd);

      // Back-to-back write then read, no idle cycle between
      xfer(1, 1'b1, 12'h10C, 32'hCAFEF00D, 4'hF, 1'b0, rd);
      xfer(1, 1'b0, 12'h10C, 32'h0, 4'h0, 1'b1, rd);
      xfer(0, 1'b1, 12'h020, 32'h01020304, 4'hF, 1'b0, rd);
      xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 1'b1, rd);

      // psel dropped mid-access: no write, next transfer normal
      @(posedge pclk); #1;
      dsel = 1; t_psel = 1'b1; t_penable = 1'b0; t_pwrite = 1'b1;
      t_paddr = 12'h110; t_pwdata = 32'h77777777; t_pstrb = 4'hF;
      @(posedge pclk); #1; t_penable = 1'b1;
      @(negedge pclk); chk("abort_A0", 32'(o_pready), 32'd0);
      @(posedge pclk); #1; t_psel = 1'b0; t_penable = 1'b0;
      @(negedge pclk); chk("abort_idle", 32'(o_pready), 32'd0);
      xfer(1, 1'b0, 12'h110, 32'h0, 4'h0, 1'b0, rd);
      chk_errc(1);

      // Randomised traffic on all three instances
      for (int n = 0; n < 80; n++) begin
         int d;
         int sel;
         d   = $urandom_range(0, 2);
         sel = $urandom_range(0, 7);
         case (sel)
            0:       ra = 12'($urandom_range(0, 3) * 4);
            1:       ra = 12'($urandom_range(4, 40) * 4 + $urandom_range(1, 3));
            2:       ra = 12'($urandom_range(256, 1023) * 4);
            default: ra = 12'($urandom_range(4, 19) * 4);
         endcase
         xfer(d, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
              1'b0, rd);
      end
      for (int d = 0; d < 3; d++) chk_errc(d);

      // Saturating error counter
      for (int n = 0; n < 300; n++)
         xfer(0, 1'b0, 12'h401, 32'h0, 4'h0, 1'b0, rd);
      chk_errc(0);
      chk("sat_errc", 32'(o_errc), 32'd255);

      // Async reset in A1 of a 3-wait write
      xfer(2, 1'b1, 12'h200, 32'h12345678, 4'hF, 1'b0, rd);
      @(posedge pclk); #1;
      dsel = 2; t_psel = 1'b1; t_penable = 1'b0; t_pwrite = 1'b1;
      t_paddr = 12'h200; t_pwdata = 32'h9ABCDEF0; t_pstrb = 4'hF;
      @(posedge pclk); #1; t_penable = 1'b1;
      @(negedge pclk); chk("rst_A0", 32'(o_pready), 32'd0);
      @(posedge pclk); #1;
      @(negedge pclk); chk("rst_A1", 32'(o_pready), 32'd0);
      #1 presetn = 1'b0;
      #1 chk("rst_async_pready", 32'(o_pready), 32'd0);
      chk("rst_async_prdata", o_prdata, 32'd0);
      t_psel = 1'b0; t_penable = 1'b0;
      model_clear();
      @(negedge pclk); presetn = 1'b1;
      chk_errc(0);
      xfer(2, 1'b0, 12'h200, 32'h0, 4'h0, 1'b0, rd);
      chk("t6_rd", rd, 32'h0);
      xfer(1, 1'b0, 12'h104, 32'h0, 4'h0, 1'b0, rd);
      xfer(2, 1'b1, 12'h204, 32'h0BADF00D, 4'hF, 1'b0, rd);
      xfer(2, 1'b0, 12'h204, 32'h0, 4'h0, 1'b1, rd);
      chk("t6_after", rd, 32'h0BADF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
